sram_port_arbiter: RTL and testbench

- Shares the single-port on-board SRAM between the instruction-fetch requester and the data-memory (load/store) requester of the CPU core.
- Sequences each access through a fixed number of SRAM wait states and returns read data with a one-cycle acknowledge.
- Generates the pipeline stall while a request is outstanding.
- Sits between the core's memory-stage byte-enable/data-alignment logic and the SRAM pins.

---
 rtl/sram_port_arbiter_if.sv | 33 +++
 rtl/sram_port_arbiter.sv | 118 +++++++++++
 tb/tb_sram_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the core-side requester ports and the SRAM pin ports of the arbiter.
// master = core + SRAM environment, slave = the arbiter itself.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              inst_ack;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_sel;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_ack;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              stall;

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_sel, data_addr, data_wdata, sram_rdata,
    input  inst_rdata, inst_ack, data_rdata, data_ack, sram_en, sram_we, sram_addr, sram_wdata, stall
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_sel, data_addr, data_wdata, sram_rdata,
    output inst_rdata, inst_ack, data_rdata, data_ack, sram_en, sram_we, sram_addr, sram_wdata, stall
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between instruction fetch and
// data load/store, with fixed wait states, one-cycle ack pulses and a pipeline stall.
module sram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input logic                clk,
  input logic                resetn,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d, gnt;
  logic [3:0]        cnt_q, cnt_d;
  logic              inst_ack_q, inst_ack_d, data_ack_q, data_ack_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic              sram_en_q, sram_en_d;
  logic [3:0]        sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;
  logic              unused_addr_lsbs;

  // Byte offset never reaches the SRAM; lane alignment happens upstream.
  assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;

    // On a tie the requester that did not win last time gets the port.
    gnt = GNT_INST;
    if (bus.data_req && (!bus.inst_req || last_grant_q == GNT_INST)) gnt = GNT_DATA;

    case (state_q)
      IDLE: begin
        sram_en_d = 1'b0;
        sram_we_d = '0;
        if (bus.inst_req || bus.data_req) begin
          state_d      = ACCESS;
          last_grant_d = gnt;
          cnt_d        = 4'(WAIT_CYCLES - 1);
          sram_en_d    = 1'b1;
          sram_addr_d  = (gnt == GNT_DATA) ? {bus.data_addr[ADDR_W-1:2], 2'b00}
                                           : {bus.inst_addr[ADDR_W-1:2], 2'b00};
          sram_wdata_d = bus.data_wdata;
          sram_we_d    = (gnt == GNT_DATA && bus.data_wr) ? bus.data_sel : '0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          sram_en_d = 1'b0;
          sram_we_d = '0;
          if (last_grant_q == GNT_DATA) begin
            data_rdata_d = bus.sram_rdata;
            data_ack_d   = 1'b1;
          end else begin
            inst_rdata_d = bus.sram_rdata;
            inst_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GNT_INST;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign bus.inst_ack   = inst_ack_q;
  assign bus.data_ack   = data_ack_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.sram_en    = sram_en_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.stall      = (bus.inst_req & ~inst_ack_q) | (bus.data_req & ~data_ack_q);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a timeline model of each access is checked
// against the outputs every cycle, plus literal expectations for the scenarios.
module tb_sram_port_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  sram_port_arbiter_if #(.ADDR_W(32)) bus ();

  sram_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an access granted at edge g drives the SRAM for edges g..g+W-1,
  // captures read data and acks at edge g+W, and is finished at edge g+W+1.
  int          cyc = 0, g = 0;
  bit          act = 0, m_own = 0, m_last = 0;
  logic        m_iack = 0, m_dack = 0, m_en = 0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_ird = '0, m_drd = '0, m_addr = '0, m_wd = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc = 0; act = 0; m_last = 0; m_own = 0;
      m_iack = 0; m_dack = 0; m_en = 0; m_we = '0;
      m_ird = '0; m_drd = '0; m_addr = '0; m_wd = '0;
    end else begin
      cyc++;
      if (act && cyc - g == W) begin
        if (m_own) begin m_drd = bus.sram_rdata; m_dack = 1; end
        else       begin m_ird = bus.sram_rdata; m_iack = 1; end
        m_en = 0; m_we = '0;
      end else if (act && cyc - g == W + 1) begin
        m_iack = 0; m_dack = 0; act = 0;
      end else if (!act && (bus.inst_req || bus.data_req)) begin
        m_own  = (bus.inst_req && bus.data_req) ? !m_last : bus.data_req;
        m_last = m_own;
        g = cyc; act = 1; m_en = 1;
        m_addr = (m_own ? bus.data_addr : bus.inst_addr) & 32'hFFFF_FFFC;
        m_wd   = bus.data_wdata;
        m_we   = (m_own && bus.data_wr) ? bus.data_sel : 4'b0000;
      end
    end
  end

  always @(negedge clk) begin
    chk("inst_ack",   64'(bus.inst_ack),   64'(m_iack));
    chk("data_ack",   64'(bus.data_ack),   64'(m_dack));
    chk("inst_rdata", 64'(bus.inst_rdata), 64'(m_ird));
    chk("data_rdata", 64'(bus.data_rdata), 64'(m_drd));
    chk("sram_en",    64'(bus.sram_en),    64'(m_en));
    chk("sram_we",    64'(bus.sram_we),    64'(m_we));
    chk("sram_addr",  64'(bus.sram_addr),  64'(m_addr));
    chk("sram_wdata", 64'(bus.sram_wdata), 64'(m_wd));
    chk("stall", 64'(bus.stall),
        64'((bus.inst_req & ~m_iack) | (bus.data_req & ~m_dack)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected ack is seen (bounded); reports the tick index,
  // SRAM-enabled cycles, OR of write enables and whether the other ack appeared.
  task automatic wait_ack(input bit is_data, output int n, output int en_cnt,
                          output logic [3:0] we_or, output bit other);
    n = -1; en_cnt = 0; we_or = '0; other = 0;
    for (int i = 1; i <= 12 && n < 0; i++) begin
      tick();
      if (bus.sram_en) en_cnt++;
      we_or |= bus.sram_we;
      if (is_data ? bus.inst_ack : bus.data_ack) other = 1;
      if (is_data ? bus.data_ack : bus.inst_ack) n = i;
    end
  endtask

  task automatic idle_reqs();
    bus.inst_req = 0; bus.data_req = 0;
    tick(); tick();
  endtask

  int          n, en_cnt, nacks;
  logic [3:0]  we_or;
  bit          other;
  int          ack_t[8];
  bit          ack_d[8];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_req = 0; bus.inst_addr = '0; bus.data_req = 0; bus.data_wr = 0;
    bus.data_sel = '0; bus.data_addr = '0; bus.data_wdata = '0; bus.sram_rdata = '0;
    tick(); tick();
    chk("reset_en", 64'(bus.sram_en), 64'd0);
    chk("reset_addr", 64'(bus.sram_addr), 64'd0);
    resetn = 1;
    tick();

    // Single load
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h0000_0106;
    bus.sram_rdata = 32'hDEADBEEF;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("load_lat", 64'(n), 64'd3);
    chk("load_en_cycles", 64'(en_cnt), 64'd2);
    chk("load_we", 64'(we_or), 64'd0);
    chk("load_rdata", 64'(bus.data_rdata), 64'hDEADBEEF);
    chk("load_addr", 64'(bus.sram_addr), 64'h104);
    idle_reqs();

    // Byte store
    bus.data_req = 1; bus.data_wr = 1; bus.data_sel = 4'b0100;
    bus.data_wdata = 32'h00AB0000; bus.data_addr = 32'h22;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("store_lat", 64'(n), 64'd3);
    chk("store_en_cycles", 64'(en_cnt), 64'd2);
    chk("store_we", 64'(we_or), 64'b0100);
    chk("store_addr", 64'(bus.sram_addr), 64'h20);
    chk("store_wdata", 64'(bus.sram_wdata), 64'h00AB0000);
    chk("store_no_inst_ack", 64'(other), 64'd0);
    idle_reqs();

    // Inputs changed mid-access are ignored
    bus.data_req = 1; bus.data_wr = 0; bus.data_sel = '0;
    bus.data_addr = 32'h40; bus.data_wdata = 32'h11111111; bus.sram_rdata = 32'h5A5A5A5A;
    tick();
    bus.data_addr = 32'h80; bus.data_wdata = 32'h22222222;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("hold_lat", 64'(n), 64'd2);
    chk("hold_addr", 64'(bus.sram_addr), 64'h40);
    chk("hold_wdata", 64'(bus.sram_wdata), 64'h11111111);
    idle_reqs();

    // Fetch only
    bus.inst_req = 1; bus.inst_addr = 32'h0000_0ABF; bus.sram_rdata = 32'hCAFEF00D;
    wait_ack(0, n, en_cnt, we_or, other);
    chk("fetch_lat", 64'(n), 64'd3);
    chk("fetch_rdata", 64'(bus.inst_rdata), 64'hCAFEF00D);
    chk("fetch_addr", 64'(bus.sram_addr), 64'hABC);
    idle_reqs();

    // Request dropped after grant still completes
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h10;
    tick();
    bus.data_req = 0;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("drop_lat", 64'(n), 64'd2);
    idle_reqs();

    // Fresh reset, then both requesters contend
    resetn = 0; tick(); tick(); resetn = 1;
    bus.inst_req = 1; bus.inst_addr = 32'h1000;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h2000;
    bus.sram_rdata = 32'hC0DE0000;
    nacks = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if ((bus.inst_ack || bus.data_ack) && nacks < 8) begin
        ack_t[nacks] = i; ack_d[nacks] = bus.data_ack; nacks++;
      end
      if (i == 3)  chk("rr_data_rdata", 64'(bus.data_rdata), 64'hC0DE0002);
      if (i == 7) begin
        chk("rr_inst_rdata", 64'(bus.inst_rdata), 64'hC0DE0006);
        chk("rr_inst_addr", 64'(bus.sram_addr), 64'h1000);
      end
      bus.sram_rdata = 32'hC0DE0000 + 32'(i);
    end
    chk("rr_nacks", 64'(nacks), 64'd4);
    for (int k = 0; k < 4 && k < nacks; k++) begin
      chk($sformatf("rr_owner%0d", k), 64'(ack_d[k]), 64'((k % 2) == 0));
      chk($sformatf("rr_tick%0d", k), 64'(ack_t[k]), 64'(3 + 4 * k));
    end
    idle_reqs();

    // Asynchronous reset during the second ACCESS cycle
    bus.data_req = 1; bus.data_wr = 1; bus.data_sel = 4'b1111;
    bus.data_addr = 32'h300; bus.data_wdata = 32'h12345678;
    tick(); tick();
    bus.inst_req = 1;
    resetn = 0;
    #1;
    chk("arst_en", 64'(bus.sram_en), 64'd0);
    chk("arst_we", 64'(bus.sram_we), 64'd0);
    chk("arst_addr", 64'(bus.sram_addr), 64'd0);
    chk("arst_wdata", 64'(bus.sram_wdata), 64'd0);
    tick();
    chk("arst_no_ack", 64'(bus.data_ack | bus.inst_ack), 64'd0);
    tick();
    resetn = 1;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("arst_first_data", 64'(n), 64'd3);
    chk("arst_no_inst_first", 64'(other), 64'd0);
    idle_reqs();

    // Store with no byte enables
    bus.data_req = 1; bus.data_wr = 1; bus.data_sel = 4'b0000;
    bus.data_addr = 32'h44; bus.data_wdata = 32'hFFFFFFFF;
    wait_ack(1, n, en_cnt, we_or, other);
    chk("zsel_lat", 64'(n), 64'd3);
    chk("zsel_en_cycles", 64'(en_cnt), 64'd2);
    chk("zsel_we", 64'(we_or), 64'd0);
    idle_reqs();

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
